// File: rtl/ext_bus_addr_seq.sv
// Sequences 32-bit core request addresses onto a 16-bit external address bus (hi/lo halves).
// Optional ack timeout is compiled in with the EXT_BUS_TMO_EN macro.
module ext_bus_addr_seq #(
    parameter int WAIT_CYC = 2,
    parameter int TMO_CYC  = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    output logic [15:0] bus_addr_o,
    output logic        bus_ale_hi_o,
    output logic        bus_ale_lo_o,
    input  logic        bus_ack_i,
    output logic        done_o,
    output logic        err_o
);

    typedef enum logic [2:0] {IDLE, HI, LO, WAIT, ACK} state_t;

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYC > 0 ? WAIT_CYC - 1 : 0);

    state_t      state_reg, state_next;
    logic [31:0] addr_reg, addr_next;
    logic [15:0] hi_q_reg, hi_q_next;
    logic        hi_valid_reg, hi_valid_next;
    logic [3:0]  wait_cnt_reg, wait_cnt_next;
    logic [15:0] bus_addr_reg, bus_addr_next;
    logic        ale_hi_reg, ale_hi_next;
    logic        ale_lo_reg, ale_lo_next;
    logic        done_reg, done_next;
    logic        ready_reg, ready_next;

`ifdef EXT_BUS_TMO_EN
    localparam logic [15:0] TMO_LAST = 16'(TMO_CYC - 1);
    logic [15:0] tmo_cnt_reg, tmo_cnt_next;
    logic        err_reg, err_next;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            addr_reg     <= '0;
            hi_q_reg     <= '0;
            hi_valid_reg <= 1'b0;
            wait_cnt_reg <= '0;
            bus_addr_reg <= '0;
            ale_hi_reg   <= 1'b0;
            ale_lo_reg   <= 1'b0;
            done_reg     <= 1'b0;
            ready_reg    <= 1'b1;
`ifdef EXT_BUS_TMO_EN
            tmo_cnt_reg  <= '0;
            err_reg      <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            hi_q_reg     <= hi_q_next;
            hi_valid_reg <= hi_valid_next;
            wait_cnt_reg <= wait_cnt_next;
            bus_addr_reg <= bus_addr_next;
            ale_hi_reg   <= ale_hi_next;
            ale_lo_reg   <= ale_lo_next;
            done_reg     <= done_next;
            ready_reg    <= ready_next;
`ifdef EXT_BUS_TMO_EN
            tmo_cnt_reg  <= tmo_cnt_next;
            err_reg      <= err_next;
`endif
        end
    end

    // Output registers are loaded from the current state, so each strobe appears
    // one cycle after the state that produces it.
    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        hi_q_next     = hi_q_reg;
        hi_valid_next = hi_valid_reg;
        wait_cnt_next = wait_cnt_reg;
        bus_addr_next = bus_addr_reg;
        ale_hi_next   = 1'b0;
        ale_lo_next   = 1'b0;
        done_next     = 1'b0;
        ready_next    = ready_reg;
`ifdef EXT_BUS_TMO_EN
        tmo_cnt_next  = tmo_cnt_reg;
        err_next      = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (req_valid_i && ready_reg) begin
                    addr_next  = req_addr_i;
                    ready_next = 1'b0;
                    if (!hi_valid_reg || req_addr_i[31:16] != hi_q_reg)
                        state_next = HI;
                    else
                        state_next = LO;
                end
            end
            HI: begin
                bus_addr_next = addr_reg[31:16];
                ale_hi_next   = 1'b1;
                hi_q_next     = addr_reg[31:16];
                hi_valid_next = 1'b1;
                state_next    = LO;
            end
            LO: begin
                bus_addr_next = addr_reg[15:0];
                ale_lo_next   = 1'b1;
                wait_cnt_next = '0;
`ifdef EXT_BUS_TMO_EN
                tmo_cnt_next  = '0;
`endif
                state_next    = (WAIT_CYC == 0) ? ACK : WAIT;
            end
            WAIT: begin
                if (wait_cnt_reg == WAIT_LAST)
                    state_next = ACK;
                else
                    wait_cnt_next = wait_cnt_reg + 4'd1;
            end
            ACK: begin
                if (bus_ack_i) begin
                    done_next  = 1'b1;
                    ready_next = 1'b1;
                    state_next = IDLE;
                end
`ifdef EXT_BUS_TMO_EN
                // A late ack on the expiry cycle is handled above and wins.
                else if (tmo_cnt_reg == TMO_LAST) begin
                    done_next     = 1'b1;
                    err_next      = 1'b1;
                    ready_next    = 1'b1;
                    hi_valid_next = 1'b0;
                    state_next    = IDLE;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + 16'd1;
                end
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    assign req_ready_o  = ready_reg;
    assign bus_addr_o   = bus_addr_reg;
    assign bus_ale_hi_o = ale_hi_reg;
    assign bus_ale_lo_o = ale_lo_reg;
    assign done_o       = done_reg;
`ifdef EXT_BUS_TMO_EN
    assign err_o        = err_reg;
`else
    assign err_o        = 1'b0;
`endif

endmodule

// File: tb/tb_ext_bus_addr_seq.sv
// Scoreboard bench for ext_bus_addr_seq: driver pushes expected transfers, a negedge monitor
// compares every output each cycle. Honours EXT_BUS_TMO_EN when defined.
module tb_ext_bus_addr_seq;

    localparam int WAIT_CYC = 2;
    localparam int TMO_CYC  = 8;
`ifdef EXT_BUS_TMO_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [15:0] bus_addr;
    logic        ale_hi;
    logic        ale_lo;
    logic        bus_ack;
    logic        done;
    logic        err;

    ext_bus_addr_seq #(.WAIT_CYC(WAIT_CYC), .TMO_CYC(TMO_CYC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_addr_i   (req_addr),
        .bus_addr_o   (bus_addr),
        .bus_ale_hi_o (ale_hi),
        .bus_ale_lo_o (ale_lo),
        .bus_ack_i    (bus_ack),
        .done_o       (done),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          hi;
        int          acc;
        int          done_cyc;
        bit          err;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    bit          hv_m = 1'b0;
    logic [15:0] hi_m = '0;
    logic [15:0] bus_m = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Monitor: expectation derived from the timing rule of the front transfer.
    exp_t e;
    bit   exp_hi, exp_lo, exp_done, exp_err, exp_ready;
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            bus_m = '0;
        end
        exp_hi = 0; exp_lo = 0; exp_done = 0; exp_err = 0;
        if (q.size() > 0) begin
            e        = q[0];
            exp_hi   = (e.hi == 1) && (cyc == e.acc + 1);
            exp_lo   = (cyc == e.acc + 1 + e.hi);
            exp_done = (cyc == e.done_cyc);
            exp_err  = exp_done && e.err;
            if (exp_hi) bus_m = e.addr[31:16];
            if (exp_lo) bus_m = e.addr[15:0];
            if (exp_done) void'(q.pop_front());
        end
        exp_ready = (q.size() == 0);
        chk("ale_hi", 32'(ale_hi), 32'(exp_hi));
        chk("ale_lo", 32'(ale_lo), 32'(exp_lo));
        chk("done", 32'(done), 32'(exp_done));
        chk("err", 32'(err), 32'(exp_err));
        chk("ready", 32'(req_ready), 32'(exp_ready));
        chk("bus_addr", 32'(bus_addr), 32'(bus_m));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [31:0] addr, input int d, output bit ok, output int hi);
        bit rdy;
        bit er;
        int base;
        ok = 0;
        hi = 0;
        req_addr  = addr;
        req_valid = 1'b1;
        for (int n = 0; n < 64 && !ok; n++) begin
            rdy = req_ready;
            tick();
            ok = rdy;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL accept addr=%h got=no_accept expected=accept", addr);
            req_valid = 1'b0;
            return;
        end
        hi   = (!hv_m || addr[31:16] != hi_m) ? 1 : 0;
        hv_m = 1'b1;
        hi_m = addr[31:16];
        base = hi + 1 + WAIT_CYC;
        er   = TMO_EN && (d >= TMO_CYC);
        if (er) hv_m = 1'b0;
        q.push_back('{addr: addr, hi: hi, acc: cyc,
                      done_cyc: cyc + base + 1 + (er ? TMO_CYC - 1 : d), err: er});
        $display("txn cyc=%0d addr=%h hi=%0d ack_delay=%0d timeout=%0d", cyc, addr, hi, d, er);
    endtask

    // Ack is random noise before ACK, low for d ACK cycles, then high for one.
    task automatic run_txn(input logic [31:0] addr, input int d, input bit hold);
        bit ok;
        int hi;
        int base;
        accept(addr, d, ok, hi);
        if (!ok) return;
        base = hi + 1 + WAIT_CYC;
        for (int k = 0; k <= base + d; k++) begin
            req_valid = hold;
            req_addr  = $urandom;
            bus_ack   = (k < base) ? 1'($urandom_range(0, 1)) : (k == base + d);
            tick();
        end
        req_valid = 1'b0;
        bus_ack   = 1'b0;
    endtask

    task automatic reset_mid(input logic [31:0] addr);
        bit ok;
        int hi;
        accept(addr, 0, ok, hi);
        if (!ok) return;
        req_valid = 1'b0;
        for (int k = 0; k < hi + 2; k++) begin
            bus_ack = 1'($urandom_range(0, 1));
            tick();
        end
        rst_n = 1'b0;
        hv_m  = 1'b0;
        tick();
        tick();
        rst_n   = 1'b1;
        bus_ack = 1'b0;
        $display("txn cyc=%0d reset asserted during WAIT", cyc);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [15:0] hpool [4];
        logic [31:0] a;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        bus_ack   = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;

        run_txn(32'h1234_5678, 0, 0);
        run_txn(32'h1234_0000, 0, 0);
        run_txn(32'h1234_0004, 0, 0);
        run_txn(32'h1234_00AA, 10, 0);
        reset_mid(32'h1234_000C);
        run_txn(32'h1234_0008, 0, 0);
        run_txn(32'hABCD_0010, 3, 1);
        run_txn(32'hABCD_0014, 0, 0);
        run_txn(32'hFFFF_FFFF, 1, 0);
        run_txn(32'h0000_0000, 0, 0);
        if (TMO_EN) begin
            run_txn(32'h5555_0000, 8, 0);
            run_txn(32'h5555_0004, 0, 0);
            run_txn(32'h5555_0008, 7, 0);
        end

        hpool[0] = 16'h1234;
        hpool[1] = 16'hFFFF;
        hpool[2] = 16'h0000;
        for (int i = 0; i < 60; i++) begin
            hpool[3] = 16'($urandom);
            a = {hpool[$urandom_range(0, 3)], 16'($urandom)};
            repeat ($urandom_range(0, 2)) tick();
            run_txn(a, ($urandom_range(0, 9) == 0) ? 9 : $urandom_range(0, 5), 0);
        end

        repeat (5) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
